uart_tx_packetizer: RTL
=======================

// Module: uart_tx_packetizer
// PURPOSE
//  Reply path of the UART control link. Captures one response packet from the
//  control logic into an internal buffer, then sends it to the txuart instance
//  as a framed byte stream: SYNC, LEN, LEN payload bytes, CHK.
//  Framing is store-and-forward, so LEN is known before the first byte is sent.
//  Sits between the control FSM and the txuart instance; the rxuart-side
//  command decoder is its peer.
// PARAMETERS
//  MAX_LEN   64     payload buffer depth in bytes; legal range 1..255
//  SYNC_BYTE 8'hA5  first byte of every frame
//  AW        $clog2(MAX_LEN)  buffer address width (derived, not overridable)
// PORTS
//  clk       in   1  system clock; all logic on the rising edge
//  rst_n     in   1  asynchronous reset, active low
//  s_data    in   8  payload byte from the control logic
//  s_valid   in   1  s_data is valid
//  s_last    in   1  s_data is the final payload byte of the packet
//  s_ready   out  1  byte accepted on this cycle when s_valid && s_ready
//  tx_busy   in   1  txuart o_busy
//  tx_wr     out  1  to txuart i_wr
//  tx_data   out  8  to txuart i_data
//  pkt_sent  out  1  one-cycle pulse after the CHK byte is accepted
//  truncated out  1  sticky flag: a packet exceeded MAX_LEN; cleared only by rst_n
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream): state=FILL, wptr=0,
//    rptr=0, chk=0. Outputs: s_ready=1, tx_wr=0, tx_data=8'h00, pkt_sent=0,
//    truncated=0.
//  FILL: s_ready=1. Each accepted byte is written to buf[wptr] and wptr
//    increments. Leave for SYNC when either:
//    - an accepted byte has s_last=1, or
//    - an accepted byte makes wptr==MAX_LEN. If that byte has s_last=0, set
//      truncated=1. Later bytes are refused (s_ready=0) until FILL returns.
//    On the transition, latch len=wptr (1..MAX_LEN) and set chk=len[7:0].
//  SYNC -> LEN -> PAY -> CHK -> FILL: s_ready=0 in all four states.
//  Byte handshake in SYNC/LEN/PAY/CHK:
//    - tx_data is loaded with the byte for the current state, then tx_wr=1 is
//      held until a cycle with tx_wr && !tx_busy. That cycle is the acceptance.
//    - On the cycle after acceptance, tx_wr=0 (mandatory one-cycle gap, because
//      txuart o_busy is registered). The next byte is then presented.
//    - Latency: FILL exit to first tx_wr=1 is 1 cycle.
//  Byte values per state:
//    - SYNC sends SYNC_BYTE.
//    - LEN sends len.
//    - PAY sends buf[rptr] and sets chk ^= buf[rptr] on acceptance. rptr
//      increments; leave for CHK when rptr==len-1 is accepted.
//    - CHK sends chk = len ^ XOR(payload).
//  CHK acceptance: pkt_sent=1 for exactly one cycle, wptr=rptr=0, state=FILL.
//    s_ready=1 from the next cycle.
//  tx_data is stable for the whole time tx_wr=1. It may only change while tx_wr=0.
//  Packet size: a 1-byte packet is legal (4 UART bytes). An empty packet cannot
//    occur, since s_last travels with data.
//  s_last without s_valid is ignored. s_valid while s_ready=0 is ignored and is
//    not buffered.
//  rst_n asserted mid-frame: the frame is aborted immediately and tx_wr drops
//    asynchronously. The partial frame is not resumed. The buffer is discarded.
//  Arithmetic: wptr/rptr are AW+1 bits, compared against len. Length is 8 bits,
//    so MAX_LEN>255 is illegal: elaboration-time $error.
// STRUCTURE
//  Shared package uart_ctrl_pkg holds:
//    - state enum constants ST_FILL, ST_SYNC, ST_LEN, ST_PAY, ST_CHK
//    - SYNC_BYTE default
//    - checksum function chk_xor()
//  The command decoder uses the same package.
//  One sub-module: uart_pkt_ram. Simple dual-port MAX_LEN x 8 RAM with
//    registered read (1-cycle). PAY prefetches buf[rptr] during the tx_wr=0 gap.
//  Everything else (FSM, pointers, checksum) stays in this module.
// TESTING
//  1. Send 3 bytes 11,22,33 (s_last on 33), tx_busy=0 -> tx stream A5,03,11,22,33,03;
//     one pkt_sent pulse; s_ready=0 from the cycle after 33 until the cycle after pkt_sent.
//  2. Send 1 byte 5A with s_last, tx_busy high 10 cycles after each accept ->
//     A5,01,5A,5B; tx_data stable while tx_wr=1; tx_wr=0 on every post-accept cycle.
//  3. Send MAX_LEN+4 bytes with no s_last -> first MAX_LEN sent, LEN=8'h40,
//     truncated=1, extra 4 bytes refused.
//  4. s_valid during SYNC..CHK -> s_ready=0, no extra bytes in next frame;
//     back-to-back packets -> both framed correctly.
//  5. Assert rst_n low in the middle of PAY -> tx_wr=0 same cycle;
//     after release s_ready=1, next packet starts with A5.
//  6. Random lengths 1..64, random tx_busy -> scoreboard: decoded LEN, payload
//     and CHK match; tx_wr never high on consecutive accept cycles.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control link: packet FSM states,
// default frame sync byte and the running checksum helper.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_SYNC,
        ST_LEN,
        ST_PAY,
        ST_CHK
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Running frame checksum: XOR accumulation seeded with the length byte.
    function automatic logic [7:0] chk_xor(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_pkt_ram.sv
// Packet payload buffer: simple dual-port RAM, one write port and one
// read port with a single-cycle registered read.
module uart_pkt_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write on request; read is registered, addresses past DEPTH return zero.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        if (32'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/uart_tx_packetizer.sv
// Reply path of the UART control link: buffers one response packet, then
// streams it to txuart as SYNC, LEN, payload, CHK with a one-cycle gap
// after every accepted byte.
module uart_tx_packetizer
    import uart_ctrl_pkg::*;
#(
    parameter int         MAX_LEN   = 64,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       tx_busy,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic       pkt_sent,
    output logic       truncated
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(MAX_LEN);
    localparam logic [PW-1:0] ONE  = PW'(1);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_len_check
        $error("uart_tx_packetizer: MAX_LEN must be in 1..255");
    end

    pkt_state_t    state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic          tx_wr_q, tx_wr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          pkt_sent_q, pkt_sent_d;
    logic          trunc_q, trunc_d;
    logic          ram_we;
    logic [7:0]    rd_data;

    // Read address follows the next rptr so the byte is ready during the gap.
    uart_pkt_ram #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_data (s_data),
        .rd_addr (rptr_d[AW-1:0]),
        .rd_data (rd_data)
    );

    // State, pointer, checksum and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            wptr_q     <= '0;
            rptr_q     <= '0;
            len_q      <= '0;
            chk_q      <= '0;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= '0;
            pkt_sent_q <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
            tx_wr_q    <= tx_wr_d;
            tx_data_q  <= tx_data_d;
            pkt_sent_q <= pkt_sent_d;
            trunc_q    <= trunc_d;
        end
    end

    // Next-state logic: fill buffer, then hand bytes to txuart one at a time.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        len_d      = len_q;
        chk_d      = chk_q;
        tx_wr_d    = tx_wr_q;
        tx_data_d  = tx_data_q;
        pkt_sent_d = 1'b0;
        trunc_d    = trunc_q;
        ram_we     = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + ONE;
                    if (s_last || (wptr_d == FULL)) begin
                        if (!s_last) begin
                            trunc_d = 1'b1;
                        end
                        len_d     = wptr_d;
                        chk_d     = 8'(wptr_d);
                        state_d   = ST_SYNC;
                        // SYNC is presented immediately; no gap precedes it.
                        tx_wr_d   = 1'b1;
                        tx_data_d = SYNC_BYTE;
                    end
                end
            end
            default: begin
                if (tx_wr_q && !tx_busy) begin
                    tx_wr_d = 1'b0;
                    case (state_q)
                        ST_SYNC: state_d = ST_LEN;
                        ST_LEN:  state_d = ST_PAY;
                        ST_PAY: begin
                            chk_d  = chk_xor(chk_q, tx_data_q);
                            rptr_d = rptr_q + ONE;
                            if (rptr_q == (len_q - ONE)) begin
                                state_d = ST_CHK;
                            end
                        end
                        ST_CHK: begin
                            pkt_sent_d = 1'b1;
                            wptr_d     = '0;
                            rptr_d     = '0;
                            state_d    = ST_FILL;
                        end
                        default: ;
                    endcase
                end else if (!tx_wr_q) begin
                    tx_wr_d = 1'b1;
                    case (state_q)
                        ST_LEN:  tx_data_d = 8'(len_q);
                        ST_PAY:  tx_data_d = rd_data;
                        ST_CHK:  tx_data_d = chk_q;
                        default: tx_data_d = SYNC_BYTE;
                    endcase
                end
            end
        endcase
    end

    assign s_ready   = (state_q == ST_FILL);
    assign tx_wr     = tx_wr_q;
    assign tx_data   = tx_data_q;
    assign pkt_sent  = pkt_sent_q;
    assign truncated = trunc_q;

endmodule
